// File: rtl/cake_rand_gen_if.sv
// ---------------------------------------------------------------------------
// cake_rand_gen_if
//   Bundles the signals between the cake-placement random generator and its
//   neighbours: the collision logic (eat, cake_x, cake_y) and the cake
//   position register (rand_num, rand_drive). busy is a status output.
//
//   eat         collision logic -> generator, one-cycle "cake eaten" pulse
//   cake_x/y    collision logic -> generator, current cake position (10 bit)
//   rand_num    generator -> position register, x then y (9 bit)
//   rand_drive  generator -> position register, strobe qualifying x
//   busy        generator status, high while a draw/issue is in progress
//
//   master : the generator side
//   slave  : the consumer / driver side (collision logic + position register)
// ---------------------------------------------------------------------------
interface cake_rand_gen_if;
   logic       eat;
   logic [9:0] cake_x;
   logic [9:0] cake_y;
   logic [8:0] rand_num;
   logic       rand_drive;
   logic       busy;

   modport master (
      input  eat, cake_x, cake_y,
      output rand_num, rand_drive, busy
   );

   modport slave (
      output eat, cake_x, cake_y,
      input  rand_num, rand_drive, busy
   );
endinterface

// File: rtl/cake_rand_gen.sv
// ---------------------------------------------------------------------------
// cake_rand_gen
//   On every eat event draws a grid-aligned, in-range (x,y) cake position
//   from a free-running 16-bit Galois LFSR and presents it on rand_num as a
//   two-beat burst: x with a one-cycle rand_drive strobe, then y on the
//   following cycle (y is held afterwards).
//
//   clk    system clock, all logic on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    cake_rand_gen_if.master:
//            eat, cake_x, cake_y  (inputs)
//            rand_num, rand_drive, busy  (registered outputs)
// ---------------------------------------------------------------------------
module cake_rand_gen #(
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          GRID      = 16,
   parameter int          X_MIN     = 16,
   parameter int          X_MAX     = 480,
   parameter int          Y_MIN     = 16,
   parameter int          Y_MAX     = 448,
   parameter int          MAX_TRIES = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   cake_rand_gen_if.master  bus
);

   // An all-zero seed would lock the LFSR, so it is swapped for the default.
   localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
   localparam logic [15:0] TAPS      = 16'hB400;
   localparam logic [8:0]  GRID_MASK = 9'(GRID - 1);
   localparam logic [8:0]  X_LO      = 9'(X_MIN);
   localparam logic [8:0]  X_HI      = 9'(X_MAX);
   localparam logic [8:0]  Y_LO      = 9'(Y_MIN);
   localparam logic [8:0]  Y_HI      = 9'(Y_MAX);
   localparam int          TRY_W     = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

   typedef enum logic [2:0] {
      IDLE,
      DRAW_X,
      DRAW_Y,
      ISSUE_X,
      ISSUE_Y
   } state_t;

   state_t            state_reg, state_next;
   logic [15:0]       lfsr_reg, lfsr_shift;
   logic [8:0]        x_reg, x_next;
   logic [8:0]        y_reg, y_next;
   logic [TRY_W-1:0]  try_cnt_reg, try_next;
   logic              fb_reg, fb_next;
   logic              pending_reg, pending_next;
   logic [8:0]        rand_num_reg, rand_num_next;
   logic              rand_drive_reg, rand_drive_next;
   logic              busy_reg, busy_next;

   logic [8:0]        cand;
   logic              x_ok, y_ok, last_try;
   logic [8:0]        y_pick;
   logic              fb_pick, y_done;

   // Bit 9 of the cake coordinates lies outside the 9-bit placement space.
   logic              unused_bits;
   assign unused_bits = ^{bus.cake_x[9], bus.cake_y[9]};

   // Right-shifting Galois LFSR: shift down, XOR taps in when bit 0 falls out.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_lfsr
         if (gi == 15) begin : g_top
            assign lfsr_shift[gi] = TAPS[gi] & lfsr_reg[0];
         end else begin : g_mid
            assign lfsr_shift[gi] = lfsr_reg[gi+1] ^ (TAPS[gi] & lfsr_reg[0]);
         end
      end
   endgenerate

   assign cand     = lfsr_reg[8:0] & ~GRID_MASK;
   assign x_ok     = (cand >= X_LO) && (cand <= X_HI);
   assign y_ok     = (cand >= Y_LO) && (cand <= Y_HI);
   assign last_try = (try_cnt_reg == LAST_TRY);

   always_comb begin
      state_next   = state_reg;
      x_next       = x_reg;
      y_next       = y_reg;
      try_next     = try_cnt_reg;
      fb_next      = fb_reg;
      // Any eat arriving outside IDLE is remembered; repeats merge.
      pending_next = pending_reg | bus.eat;
      y_pick       = cand;
      fb_pick      = fb_reg;
      y_done       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.eat || pending_reg) begin
               state_next   = DRAW_X;
               pending_next = 1'b0;
               try_next     = '0;
               fb_next      = 1'b0;
            end
         end
         DRAW_X: begin
            if (x_ok) begin
               x_next     = cand;
               try_next   = '0;
               state_next = DRAW_Y;
            end else if (last_try) begin
               x_next     = X_LO;
               fb_next    = 1'b1;
               try_next   = '0;
               state_next = DRAW_Y;
            end else begin
               try_next   = try_cnt_reg + 1'b1;
            end
         end
         DRAW_Y: begin
            if (y_ok) begin
               y_done = 1'b1;
            end else if (last_try) begin
               y_pick  = Y_LO;
               fb_pick = 1'b1;
               y_done  = 1'b1;
            end else begin
               try_next = try_cnt_reg + 1'b1;
            end
            if (y_done) begin
               y_next   = y_pick;
               fb_next  = fb_pick;
               try_next = '0;
               // A pair equal to the current cake is redrawn, unless a
               // fallback was used (redrawing could then loop forever).
               if (!fb_pick && (x_reg == bus.cake_x[8:0]) &&
                   (y_pick == bus.cake_y[8:0])) begin
                  state_next = DRAW_X;
               end else begin
                  state_next = ISSUE_X;
               end
            end
         end
         ISSUE_X: state_next = ISSUE_Y;
         ISSUE_Y: state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      rand_drive_next = (state_next == ISSUE_X);
      rand_num_next   = rand_num_reg;
      if (state_next == ISSUE_X) begin
         rand_num_next = x_next;
      end else if (state_next == ISSUE_Y) begin
         rand_num_next = y_next;
      end
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         lfsr_reg       <= SEED_EFF;
         x_reg          <= '0;
         y_reg          <= '0;
         try_cnt_reg    <= '0;
         fb_reg         <= 1'b0;
         pending_reg    <= 1'b0;
         rand_num_reg   <= '0;
         rand_drive_reg <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         lfsr_reg       <= lfsr_shift;
         x_reg          <= x_next;
         y_reg          <= y_next;
         try_cnt_reg    <= try_next;
         fb_reg         <= fb_next;
         pending_reg    <= pending_next;
         rand_num_reg   <= rand_num_next;
         rand_drive_reg <= rand_drive_next;
         busy_reg       <= busy_next;
      end
   end

   assign bus.rand_num   = rand_num_reg;
   assign bus.rand_drive = rand_drive_reg;
   assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_cake_rand_gen.sv
// ---------------------------------------------------------------------------
// tb_cake_rand_gen
//   Two generator instances: dut_a with default ranges, dut_b with
//   X_MIN=X_MAX=496 so most x draws are rejected and the fallback path runs.
//   A reference LFSR runs alongside; expected pairs and strobe latencies are
//   derived from it by walking the draw/reject/collision rules.
// ---------------------------------------------------------------------------
module tb_cake_rand_gen;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cake_rand_gen_if bus_a ();
   cake_rand_gen_if bus_b ();

   cake_rand_gen #(.SEED(SEED)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   cake_rand_gen #(.SEED(SEED), .X_MIN(496), .X_MAX(496)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   int n_checks = 0;
   int n_err    = 0;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   function automatic logic [15:0] adv(input logic [15:0] l, input int n);
      logic [15:0] r;
      r = l;
      for (int i = 0; i < n; i++) r = lfsr_step(r);
      return r;
   endfunction

   // Reference LFSR: value held during the cycle that ends at the next edge.
   logic [15:0] m_lfsr;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= SEED;
      else        m_lfsr <= lfsr_step(m_lfsr);
   end

   // l_eat: LFSR value in the cycle whose closing edge samples eat.
   // off: cycles from that edge to the strobe; ystart: first DRAW_Y cycle.
   function automatic void predict(input logic [15:0] l_eat,
                                   input int xmin, input int xmax,
                                   input int ymin, input int ymax,
                                   input logic [8:0] cx, input logic [8:0] cy,
                                   output logic [8:0] px, output logic [8:0] py,
                                   output int off, output int ystart);
      logic [15:0] l;
      logic [8:0]  c;
      int          tries;
      bit          fb, got, done;
      l = lfsr_step(l_eat);
      off = 1; ystart = 0; done = 0; px = '0; py = '0;
      for (int pass = 0; pass < 64 && !done; pass++) begin
         fb = 0; got = 0; tries = 0;
         while (!got) begin
            c = l[8:0] & 9'h1F0;
            l = lfsr_step(l);
            off++;
            if (int'(c) >= xmin && int'(c) <= xmax) begin
               px = c; got = 1;
            end else begin
               tries++;
               if (tries == 8) begin px = 9'(xmin); fb = 1; got = 1; end
            end
         end
         if (ystart == 0) ystart = off;
         got = 0; tries = 0;
         while (!got) begin
            c = l[8:0] & 9'h1F0;
            l = lfsr_step(l);
            off++;
            if (int'(c) >= ymin && int'(c) <= ymax) begin
               py = c; got = 1;
            end else begin
               tries++;
               if (tries == 8) begin py = 9'(ymin); fb = 1; got = 1; end
            end
         end
         done = fb || (px != cx) || (py != cy);
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic rd(input bit use_b);
      return use_b ? bus_b.rand_drive : bus_a.rand_drive;
   endfunction

   function automatic logic [8:0] rn(input bit use_b);
      return use_b ? bus_b.rand_num : bus_a.rand_num;
   endfunction

   function automatic logic bz(input bit use_b);
      return use_b ? bus_b.busy : bus_a.busy;
   endfunction

   task automatic set_eat(input bit use_b, input logic v);
      if (use_b) bus_b.eat = v;
      else       bus_a.eat = v;
   endtask

   // One eat on an idle generator; checks strobe timing, x, y, and busy drop.
   task automatic run_single(input bit use_b, input logic [9:0] cx, input logic [9:0] cy,
                             input int xmin, input int xmax, input int ymin, input int ymax,
                             input string tag,
                             output logic [8:0] gx, output logic [8:0] gy, output int lat);
      logic [8:0] px, py;
      int         off, ys;
      bit         seen;
      if (use_b) begin bus_b.cake_x = cx; bus_b.cake_y = cy; end
      else       begin bus_a.cake_x = cx; bus_a.cake_y = cy; end
      predict(m_lfsr, xmin, xmax, ymin, ymax, cx[8:0], cy[8:0], px, py, off, ys);
      set_eat(use_b, 1'b1);
      seen = 0; lat = 0; gx = '0; gy = '0;
      for (int k = 1; k <= 80 && !seen; k++) begin
         @(negedge clk);
         if (k == 1) set_eat(use_b, 1'b0);
         if (rd(use_b)) begin seen = 1; lat = k; gx = rn(use_b); end
      end
      check({tag, " strobe seen"}, 32'(seen), 1);
      check({tag, " latency"}, lat, off);
      check({tag, " x"}, gx, px);
      check({tag, " busy at strobe"}, bz(use_b), 1);
      @(negedge clk);
      gy = rn(use_b);
      check({tag, " y"}, gy, py);
      check({tag, " drive low on y"}, rd(use_b), 0);
      @(negedge clk);
      check({tag, " busy low"}, bz(use_b), 0);
      check({tag, " y held"}, rn(use_b), py);
   endtask

   // Drives eat on dut_a per eat_mask (bit k = negedge k) and expects exactly
   // two bursts: the first eat and one pending service.
   task automatic burst_seq(input string tag, input logic [63:0] eat_mask);
      logic [8:0] px1, py1, px2, py2, x1, x2, y2;
      int         off1, off2, ys, s1, s2, nstb, b2b;
      bit         prev;
      bus_a.cake_x = '0; bus_a.cake_y = '0;
      predict(m_lfsr, 16, 480, 16, 448, 9'd0, 9'd0, px1, py1, off1, ys);
      predict(adv(m_lfsr, off1 + 2), 16, 480, 16, 448, 9'd0, 9'd0, px2, py2, off2, ys);
      nstb = 0; b2b = 0; prev = 0; s1 = 0; s2 = 0; x1 = '0; x2 = '0; y2 = '0;
      for (int k = 0; k < 64; k++) begin
         if (k > 0) begin
            if (prev && nstb == 2) y2 = bus_a.rand_num;
            if (bus_a.rand_drive) begin
               if (prev) b2b++;
               if (nstb == 0) begin s1 = k; x1 = bus_a.rand_num; end
               else if (nstb == 1) begin s2 = k; x2 = bus_a.rand_num; end
               nstb++;
            end
            prev = bus_a.rand_drive;
         end
         bus_a.eat = eat_mask[k];
         @(negedge clk);
      end
      bus_a.eat = 1'b0;
      check({tag, " strobe count"}, nstb, 2);
      check({tag, " back-to-back strobes"}, b2b, 0);
      check({tag, " first strobe"}, s1, off1);
      check({tag, " first x"}, x1, px1);
      check({tag, " second strobe"}, s2, off1 + 2 + off2);
      check({tag, " second x"}, x2, px2);
      check({tag, " second y"}, y2, py2);
      check({tag, " spacing"}, s2 - s1, off2 + 2);
      check({tag, " spacing >= 5"}, 32'(s2 - s1 >= 5), 1);
   endtask

   typedef struct {
      int         gap;
      bit         use_b;
      logic [9:0] cx;
      logic [9:0] cy;
      int         x_lo;
      int         x_hi;
      int         y_lo;
      int         y_hi;
   } vec_t;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[4];
      logic [8:0]  gx, gy, px0, py0;
      logic [63:0] mask;
      int          lat, off0, ys, nstb, nbusy;

      vecs[0] = '{0, 1'b0, 10'd0,   10'd0,   16,  480, 16, 448};
      vecs[1] = '{3, 1'b1, 10'd0,   10'd0,   496, 496, 16, 448};
      vecs[2] = '{5, 1'b0, 10'h200, 10'h200, 16,  480, 16, 448};
      vecs[3] = '{1, 1'b0, 10'd480, 10'd16,  16,  480, 16, 448};

      bus_a.eat = 1'b0; bus_a.cake_x = '0; bus_a.cake_y = '0;
      bus_b.eat = 1'b0; bus_b.cake_x = '0; bus_b.cake_y = '0;

      // Reset state, then a long idle stretch with no eat.
      repeat (3) @(negedge clk);
      check("reset rand_num", bus_a.rand_num, 0);
      check("reset rand_drive", bus_a.rand_drive, 0);
      check("reset busy", bus_a.busy, 0);
      check("reset rand_num b", bus_b.rand_num, 0);
      rst_n = 1'b1;
      nstb = 0; nbusy = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus_a.rand_drive || bus_b.rand_drive) nstb++;
         if (bus_a.busy || bus_b.busy) nbusy++;
      end
      check("idle strobes", nstb, 0);
      check("idle busy cycles", nbusy, 0);

      // Single-eat vectors.
      for (int i = 0; i < 4; i++) begin
         repeat (vecs[i].gap) @(negedge clk);
         run_single(vecs[i].use_b, vecs[i].cx, vecs[i].cy,
                    vecs[i].x_lo, vecs[i].x_hi, vecs[i].y_lo, vecs[i].y_hi,
                    $sformatf("vec%0d", i), gx, gy, lat);
         check($sformatf("vec%0d x range", i), 32'(int'(gx) >= vecs[i].x_lo && int'(gx) <= vecs[i].x_hi), 1);
         check($sformatf("vec%0d y range", i), 32'(int'(gy) >= vecs[i].y_lo && int'(gy) <= vecs[i].y_hi), 1);
         check($sformatf("vec%0d grid", i), {gx[3:0], gy[3:0]}, 0);
      end

      // Collision: cake placed on the pair the generator would draw first
      // (bit 9 set to show it is ignored).
      predict(m_lfsr, 16, 480, 16, 448, 9'd0, 9'd0, px0, py0, off0, ys);
      run_single(1'b0, {1'b1, px0}, {1'b1, py0}, 16, 480, 16, 448, "collide", gx, gy, lat);
      check("collide delayed", 32'(lat >= off0 + 2), 1);
      check("collide pair differs", 32'({gx, gy} != {px0, py0}), 1);

      // eat at t, t+2, t+3: one pending service, third merged.
      burst_seq("merge", 64'h0000_0000_0000_000D);

      // eat landing in ISSUE_Y becomes pending.
      predict(m_lfsr, 16, 480, 16, 448, 9'd0, 9'd0, px0, py0, off0, ys);
      mask = 64'd1;
      mask[off0 + 1] = 1'b1;
      burst_seq("issue_y eat", mask);

      // Reset asserted while in DRAW_Y.
      bus_a.cake_x = '0; bus_a.cake_y = '0;
      predict(m_lfsr, 16, 480, 16, 448, 9'd0, 9'd0, px0, py0, off0, ys);
      bus_a.eat = 1'b1;
      nstb = 0;
      for (int k = 1; k <= ys; k++) begin
         @(negedge clk);
         bus_a.eat = 1'b0;
         if (bus_a.rand_drive) nstb++;
      end
      check("rst busy before", bus_a.busy, 1);
      rst_n = 1'b0;
      #1;
      check("rst rand_num", bus_a.rand_num, 0);
      check("rst rand_drive", bus_a.rand_drive, 0);
      check("rst busy", bus_a.busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus_a.rand_drive || bus_a.busy) nstb++;
      end
      check("rst no strobe", nstb, 0);
      run_single(1'b0, 10'd0, 10'd0, 16, 480, 16, 448, "post-reset", gx, gy, lat);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
